csa_group_serial_adder: RTL and testbench

- Multi-cycle carry-skip adder: computes WIDTH-bit a+b+cin, one GROUP-bit slice per clock.
- Each cycle the slice ripple-adds one group and forms that group's carry-out through the skip path: cin_next = (AND of per-bit (a|b)) & carry_in | ripple_cout.
- cin_next is registered and becomes the next group's carry-in.
- Sits between the operand source and the result consumer of the adders datapath; valid/ready handshake on both sides.

---
 rtl/csa_group_serial_adder_pkg.sv | 22 ++
 rtl/csa_group_serial_adder_slice.sv | 39 +++
 rtl/csa_group_serial_adder.sv | 157 +++++++++++++++
 tb/tb_csa_group_serial_adder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_group_serial_adder_pkg.sv
// Purpose: shared types and defaults for the group-serial carry-skip adder.
// Contents: FSM state encoding, default WIDTH/GROUP, index-width helper.
// Used by: csa_group_serial_adder (top) and csa_group_serial_adder_slice.
package csa_group_serial_adder_pkg;

  // State encoding is fixed so that waveforms and any external decode agree.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_GROUP = 4;

  // Width of a counter that only has to reach n-1. It is never zero, so a
  // single-group configuration still gets a legal one-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/csa_group_serial_adder_slice.sv
// Purpose: combinational carry-skip slice. It ripple-adds one GROUP-bit group
//          and forms the group carry-out through the skip path.
// Ports:   a_g/b_g/c_in in; s_g (group sum), ripple_cout, skip_hit (P & c_in),
//          cin_next (skip_hit | ripple_cout) out. Latency: 0 cycles, no state.
module csa_group_serial_adder_slice
  import csa_group_serial_adder_pkg::*;
#(
  parameter int GROUP = DEFAULT_GROUP
) (
  input  logic [GROUP-1:0] a_g,
  input  logic [GROUP-1:0] b_g,
  input  logic             c_in,
  output logic [GROUP-1:0] s_g,
  output logic             ripple_cout,
  output logic             skip_hit,
  output logic             cin_next
);

  // carry[i] is the carry into bit i of the group.
  logic [GROUP:0] carry;
  logic           grp_prop;

  assign carry[0] = c_in;

  for (genvar i = 0; i < GROUP; i++) begin : g_ripple
    assign s_g[i]       = a_g[i] ^ b_g[i] ^ carry[i];
    assign carry[i + 1] = (a_g[i] & b_g[i]) | ((a_g[i] ^ b_g[i]) & carry[i]);
  end

  assign ripple_cout = carry[GROUP];

  // The group propagate uses OR, not XOR. A bit that generates also passes an
  // incoming carry. Using OR therefore cannot give a wrong skip carry. It can
  // only report skip hits in cases where the ripple chain would also carry.
  assign grp_prop = &(a_g | b_g);
  assign skip_hit = grp_prop & c_in;
  assign cin_next = skip_hit | ripple_cout;

endmodule

// File: rtl/csa_group_serial_adder.sv
// Purpose: multi-cycle carry-skip adder. It computes WIDTH-bit a+b+cin, one
//          GROUP-bit group per clock, least-significant group first.
// Ports:   clk/rst (sync, active-high); in_valid/in_ready + a/b/cin operands;
//          out_valid/out_ready + sum/cout/skip_count results. Latency: result
//          valid NGROUPS edges after accept; in_ready low until the result is taken.
module csa_group_serial_adder
  import csa_group_serial_adder_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int GROUP   = DEFAULT_GROUP,
  // WIDTH must be an integer multiple of GROUP. The derived values below
  // assume this and do not check it.
  parameter int NGROUPS = WIDTH / GROUP,
  parameter int CW      = $clog2(NGROUPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [CW-1:0]    skip_count
);

  localparam int             IW       = idx_width(NGROUPS);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NGROUPS - 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CW-1:0]      skip_q, skip_d;

  logic [GROUP-1:0]   s_g;
  logic               ripple_cout;
  logic               skip_hit;
  logic               cin_next;

  // The new group sum enters the top of the sum register, and the register
  // shifts right by one group. After NGROUPS shifts, group 0 is at the bottom.
  // The concatenation keeps the slice legal when WIDTH == GROUP.
  logic [WIDTH+GROUP-1:0] sum_ins;
  assign sum_ins = {s_g, sum_q};

  csa_group_serial_adder_slice #(
    .GROUP (GROUP)
  ) u_slice (
    .a_g         (a_sh_q[GROUP-1:0]),
    .b_g         (b_sh_q[GROUP-1:0]),
    .c_in        (carry_q),
    .s_g         (s_g),
    .ripple_cout (ripple_cout),
    .skip_hit    (skip_hit),
    .cin_next    (cin_next)
  );

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      skip_q  <= skip_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    skip_d  = skip_q;

    unique case (state_q)
      IDLE: begin
        // in_ready is 1 in IDLE whenever rst is low. When rst is high, the
        // reset branch of the register block overrides this update.
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          idx_d   = '0;
          skip_d  = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        a_sh_d  = a_sh_q >> GROUP;
        b_sh_d  = b_sh_q >> GROUP;
        sum_d   = sum_ins[WIDTH+GROUP-1:GROUP];
        carry_d = cin_next;
        if (skip_hit) begin
          skip_d = skip_q + CW'(1);
        end
        if (idx_q == LAST_IDX) begin
          cout_d  = cin_next;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      DONE: begin
        // Results stay in their registers after the transfer. They change
        // only when the next addition starts shifting.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE);
  assign sum        = sum_q;
  assign cout       = cout_q;
  assign skip_count = skip_q;

endmodule

// File: tb/tb_csa_group_serial_adder.sv
module tb_csa_group_serial_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // ---------------- 32-bit / GROUP=4 instance ----------------
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [31:0] a, b, sum;
  logic [3:0]  skip_count;

  csa_group_serial_adder #(.WIDTH(32), .GROUP(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .skip_count(skip_count)
  );

  // ---------------- 16-bit / GROUP=4 instance ----------------
  logic        in_valid16, in_ready16, cin16, out_valid16, out_ready16, cout16;
  logic [15:0] a16, b16, sum16;
  logic [2:0]  skip16;

  csa_group_serial_adder #(.WIDTH(16), .GROUP(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .out_valid(out_valid16), .out_ready(out_ready16),
    .sum(sum16), .cout(cout16), .skip_count(skip16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout at cycle %0d", name, cyc);
  endtask

  // Reference: a group counts as a skip hit when every bit has a|b set and
  // the carry into the group is 1. The carry chain comes from plain addition.
  function automatic int ref_skip(input logic [31:0] ra, input logic [31:0] rb,
                                  input logic rc, input int ng);
    int   n = 0;
    logic c = rc;
    for (int g = 0; g < ng; g++) begin
      logic [3:0] ga, gb;
      logic [4:0] t;
      ga = ra[g*4 +: 4];
      gb = rb[g*4 +: 4];
      if (((ga | gb) == 4'hF) && c) n++;
      t = {1'b0, ga} + {1'b0, gb} + {4'b0, c};
      c = t[4];
    end
    return n;
  endfunction

  // One transaction on the 32-bit DUT with out_ready=1. Returns results and
  // the number of edges from the accept edge to the first sample with out_valid.
  task automatic txn32(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                       output logic [31:0] rs, output logic rco, output logic [3:0] rsk,
                       output int lat);
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (n >= 100) timeout("wait_in_ready");
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tc;   // post-accept changes must not matter
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    if (lat >= 100) timeout("wait_out_valid");
    rs = sum; rco = cout; rsk = skip_count;
    @(posedge clk); #1;   // out_ready=1: transfer at this edge
  endtask

  typedef struct {
    logic [31:0] va, vb;
    logic        vc;
    logic [31:0] es;
    logic        ec;
    logic [3:0]  ek;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] rs;
    logic        rco;
    logic [3:0]  rsk;
    int          lat;
    int          acc[3];

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 4'd7};
    vecs[1] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 4'd0};
    vecs[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 4'd0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 4'd8};
    vecs[4] = '{32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 4'd0};
    vecs[5] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 4'd0};
    vecs[6] = '{32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 32'h00000000, 1'b1, 4'd8};
    vecs[7] = '{32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 4'd3};

    rst = 1'b1;
    in_valid = 0; a = 0; b = 0; cin = 0; out_ready = 1'b1;
    in_valid16 = 0; a16 = 0; b16 = 0; cin16 = 0; out_ready16 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_in_ready_forced_low", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    chk("reset_skip", skip_count, 0);
    chk("reset_in_ready", in_ready, 1);

    // Idle with in_valid low: nothing changes.
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_in_ready", in_ready, 1);
    chk("idle_hold_out_valid", out_valid, 0);

    // Directed table.
    foreach (vecs[i]) begin
      txn32(vecs[i].va, vecs[i].vb, vecs[i].vc, rs, rco, rsk, lat);
      chk($sformatf("vec%0d_sum", i), rs, vecs[i].es);
      chk($sformatf("vec%0d_cout", i), rco, vecs[i].ec);
      chk($sformatf("vec%0d_skip", i), rsk, vecs[i].ek);
      if (i == 0) chk("latency_accept_to_valid", lat, 8);
    end

    // Backpressure: hold out_ready low and offer new operands while in DONE.
    out_ready = 1'b0;
    a = 32'hFFFFFFFF; b = 32'h00000001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin
      int n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) timeout("bp_wait_out_valid");
    end
    for (int k = 0; k < 5; k++) begin
      a = 32'h12345678; b = 32'h11111111; cin = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_out_valid", k), out_valid, 1);
      chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
      chk($sformatf("bp%0d_result", k), {skip_count, cout, sum}, {4'd7, 1'b1, 32'h0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_sum_kept", sum, 32'h0);

    // Reset during the third BUSY cycle aborts the addition.
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;            // accept edge k
    in_valid = 1'b0;
    @(posedge clk); #1;            // edge k+1
    @(posedge clk); #1;            // edge k+2
    rst = 1'b1;
    #1;
    chk("busy_rst_in_ready", in_ready, 0);
    @(posedge clk); #1;            // edge k+3 samples rst
    rst = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 0);
    chk("abort_in_ready", in_ready, 1);
    begin
      int n = 0;
      while (n < 12) begin
        @(posedge clk); #1; n++;
        if (out_valid) begin
          chk("abort_no_result", out_valid, 0);
          break;
        end
      end
    end
    txn32(32'h5, 32'h3, 1'b0, rs, rco, rsk, lat);
    chk("after_abort_sum", rs, 32'h8);
    chk("after_abort_cout", rco, 0);

    // Back-to-back with in_valid and out_ready held high: accepts 10 apart.
    in_valid = 1'b1;
    for (int t = 0; t < 3; t++) begin
      logic [31:0] ea, eb;
      int n = 0;
      ea = 32'h01010101 * (t + 3);
      eb = 32'hF0000001 + t;
      a = ea; b = eb; cin = t[0];
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) timeout("b2b_wait_in_ready");
      acc[t] = cyc + 1;
      @(posedge clk); #1;
      a = 32'hDEADBEEF; b = 32'h0BADF00D;
      n = 0;
      while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
      if (n >= 100) timeout("b2b_wait_out_valid");
      chk($sformatf("b2b%0d_sum", t), {cout, sum}, {1'b0, ea} + {1'b0, eb} + {32'b0, t[0]});
      chk($sformatf("b2b%0d_skip", t), skip_count, ref_skip(ea, eb, t[0], 8));
    end
    in_valid = 1'b0;
    chk("b2b_spacing01", acc[1] - acc[0], 10);
    chk("b2b_spacing12", acc[2] - acc[1], 10);

    // Random vectors on both widths in parallel, with random handshake gaps.
    fork
      begin
        for (int v = 0; v < 1000; v++) begin
          logic [31:0] ra, rb;
          logic        rc;
          int          n = 0;
          ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
          if (v % 4 == 0) rb = ~ra;          // force long propagate chains
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
          if (n >= 100) timeout("r32_wait_in_ready");
          a = ra; b = rb; cin = rc; in_valid = 1'b1; out_ready = 1'b0;
          @(posedge clk); #1;
          in_valid = 1'b0; a = $urandom; b = $urandom;
          n = 0;
          while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
          if (n >= 100) timeout("r32_wait_out_valid");
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          chk("r32_sum", {cout, sum}, {1'b0, ra} + {1'b0, rb} + {32'b0, rc});
          chk("r32_skip", skip_count, ref_skip(ra, rb, rc, 8));
          out_ready = 1'b1;
          @(posedge clk); #1;
          out_ready = 1'b0;
        end
      end
      begin
        for (int v = 0; v < 1000; v++) begin
          logic [15:0] ra, rb;
          logic        rc;
          int          n = 0;
          ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
          if (v % 4 == 0) rb = ~ra;
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          while (!in_ready16 && n < 100) begin @(posedge clk); #1; n++; end
          if (n >= 100) timeout("r16_wait_in_ready");
          a16 = ra; b16 = rb; cin16 = rc; in_valid16 = 1'b1; out_ready16 = 1'b0;
          @(posedge clk); #1;
          in_valid16 = 1'b0; a16 = 16'($urandom);
          n = 0;
          while (!out_valid16 && n < 100) begin @(posedge clk); #1; n++; end
          if (n >= 100) timeout("r16_wait_out_valid");
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          chk("r16_sum", {cout16, sum16}, {1'b0, ra} + {1'b0, rb} + {16'b0, rc});
          chk("r16_skip", skip16, ref_skip({16'b0, ra}, {16'b0, rb}, rc, 4));
          out_ready16 = 1'b1;
          @(posedge clk); #1;
          out_ready16 = 1'b0;
        end
      end
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
